// File: rtl/fifo_wr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_rr_arbiter
//   Shares the single write port of one synchronous FIFO between NUM_REQ
//   requesters. Ownership is handed out round-robin. An owner keeps the port
//   until it sends a beat flagged with req_last, reaches MAX_BURST beats, or
//   presents no valid beat. Each release costs one IDLE cycle.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous, active-high reset
//   req_valid     per-requester beat valid
//   req_last      per-requester end-of-packet (qualified by req_valid)
//   req_data      requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-requester ready; a beat moves when valid && ready
//   fifo_full     FIFO full flag; no write is issued while high
//   fifo_wr_cs    FIFO write chip select (identical to fifo_wr_en)
//   fifo_wr_en    FIFO write enable, one beat per high cycle
//   fifo_data_in  FIFO write data (0 while not busy)
//   grant_id      index of the current owner (meaningful while busy)
//   busy          high while a requester owns the write port
// ---------------------------------------------------------------------------
module fifo_wr_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  // Unpack the flat data bus so the owner's slice is a plain array select.
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready[gi]    = busy && !fifo_full && (grant_q == IDW'(gi));
  end

  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  xfer;
  logic                  last_beat;

  assign busy        = (state_q == BURST);
  assign owner_valid = req_valid[grant_q];
  assign owner_last  = req_last[grant_q];
  assign owner_data  = req_data_arr[grant_q];
  assign xfer        = busy && owner_valid && !fifo_full;
  // beat_cnt counts beats already written in this grant, so the beat being
  // written now is the last allowed one when the count reaches MAX_BURST-1.
  assign last_beat   = (beat_cnt_q == CW'(MAX_BURST - 1));

  assign fifo_wr_en   = xfer;
  assign fifo_wr_cs   = xfer;
  assign fifo_data_in = busy ? owner_data : '0;
  assign grant_id     = grant_q;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW:0]   cand_sum;

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      end
      if (!found && req_valid[cand_sum[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand_sum[IDW-1:0];
      end
    end
  end

  // Pointer value after the current owner releases: owner + 1, wrapping.
  logic [IDW:0]   next_sum;
  logic [IDW-1:0] grant_next;

  always_comb begin
    next_sum   = {1'b0, grant_q} + (IDW+1)'(1);
    grant_next = next_sum[IDW-1:0];
    if (next_sum >= (IDW+1)'(NUM_REQ)) begin
      grant_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (!owner_valid) begin
          // Owner has nothing to send: give the port up without writing.
          state_d  = IDLE;
          rr_ptr_d = grant_next;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (owner_last || last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = grant_next;
          end
        end
        // fifo_full with a valid owner: stall, grant and count held.
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_rr_arbiter
//   Randomised and directed stimulus for fifo_wr_rr_arbiter. A transaction
//   level model predicts, per cycle, the owner, ready vector and FIFO write;
//   predictions go into queues that a separate monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_fifo_wr_rr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_cs;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  fifo_wr_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_cs  (fifo_wr_cs),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           busy;
    logic [IDW-1:0] gid;
    logic [N-1:0]   ready;
    logic           wr;
    logic [DW-1:0]  data;
  } cyc_t;

  typedef struct packed {
    logic [IDW-1:0] gid;
    logic [DW-1:0]  data;
  } wr_t;

  cyc_t         cyc_q[$];
  wr_t          wr_q[$];
  logic [DW:0]  bq[N][$];   // per-requester pending beats {last, data}

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: owner (-1 = nobody), search start, beats sent.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_acc   = -1;

  logic [N-1:0] en = '0;
  int full_hold = 0;
  int full_pct  = 0;
  int valid_pct = 100;

  task automatic model_eval();
    cyc_t c;
    int   o;
    bit   chosen;
    c      = '0;
    m_acc  = -1;
    chosen = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!chosen && req_valid[j]) begin
          chosen  = 1;
          m_owner = j;
          m_cnt   = 0;
        end
      end
    end else begin
      o       = m_owner;
      c.busy  = 1'b1;
      c.gid   = IDW'(o);
      c.data  = req_data[o*DW +: DW];
      c.ready = fifo_full ? '0 : N'(1 << o);
      if (req_valid[o] && !fifo_full) begin
        c.wr = 1'b1;
        wr_q.push_back({IDW'(o), req_data[o*DW +: DW]});
        m_acc = o;
        m_cnt++;
        if (req_last[o] || m_cnt == MB) begin
          m_ptr   = (o + 1) % N;
          m_owner = -1;
        end
      end else if (!req_valid[o]) begin
        m_ptr   = (o + 1) % N;
        m_owner = -1;
      end
    end
    cyc_q.push_back(c);
  endtask

  task automatic drive_inputs(input bit upd_full);
    logic [DW:0] head;
    for (int i = 0; i < N; i++) begin
      if (en[i] && bq[i].size() > 0 && $urandom_range(99) < valid_pct) begin
        head                 = bq[i][0];
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = head[DW-1:0];
        req_last[i]          = head[DW];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'($urandom_range(1));
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    if (upd_full) begin
      if (full_hold > 0) begin
        fifo_full = 1'b1;
        full_hold--;
      end else begin
        fifo_full = ($urandom_range(99) < full_pct);
      end
    end
  endtask

  task automatic step();
    logic [DW:0] tmp;
    @(negedge clk);
    if (!rst) model_eval();
    else      m_acc = -1;
    @(posedge clk);
    #1;
    if (m_acc >= 0) tmp = bq[m_acc].pop_front();
    drive_inputs(1'b1);
  endtask

  task automatic set_en(input logic [N-1:0] mask);
    en = mask;
    drive_inputs(1'b0);
  endtask

  task automatic load(input int i, input int n, input int base, input bit last_end);
    for (int k = 0; k < n; k++) begin
      bq[i].push_back({(last_end && k == n-1), DW'(base + k)});
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1;
    for (int i = 0; i < N; i++) if (bq[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic drain(input string name, input int limit);
    int c;
    c = 0;
    while (!all_empty() && c < limit) begin
      step();
      c++;
    end
    repeat (3) step();
    vectors++;
    if (!all_empty()) begin
      miscompares++;
      $display("FAIL %s: beats still pending after %0d cycles, required 0 pending", name, limit);
    end
  endtask

  task automatic wait_size(input string name, input int i, input int n, input int limit);
    int c;
    c = 0;
    while (bq[i].size() > n && c < limit) begin
      step();
      c++;
    end
    vectors++;
    if (bq[i].size() > n) begin
      miscompares++;
      $display("FAIL %s: requester %0d has %0d beats left, required <= %0d", name, i, bq[i].size(), n);
    end
  endtask

  // Asserted a few ns after a rising edge, i.e. mid-cycle.
  task automatic do_reset(input int ncyc);
    #2;
    rst     = 1'b1;
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_acc   = -1;
    #1;
    vectors++;
    if ({req_ready, fifo_wr_en, fifo_wr_cs, fifo_data_in, grant_id, busy} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: outputs ready=%b wr=%b cs=%b data=%h gid=%0d busy=%b, required all 0",
               req_ready, fifo_wr_en, fifo_wr_cs, fifo_data_in, grant_id, busy);
    end
    repeat (ncyc) step();
    #2;
    rst = 1'b0;
  endtask

  // Monitor: one line per cycle check, one per FIFO write.
  initial begin
    cyc_t c;
    wr_t  w;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        vectors++;
        if ({req_ready, fifo_wr_en, fifo_wr_cs, fifo_data_in, grant_id, busy} !== '0) begin
          miscompares++;
          $display("FAIL reset_outputs: ready=%b wr=%b data=%h gid=%0d busy=%b, required all 0",
                   req_ready, fifo_wr_en, fifo_data_in, grant_id, busy);
        end
      end else if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        vectors++;
        if (busy !== c.busy || req_ready !== c.ready || fifo_wr_en !== c.wr ||
            fifo_wr_cs !== c.wr || fifo_data_in !== c.data ||
            (c.busy && grant_id !== c.gid)) begin
          miscompares++;
          $display("FAIL cycle t=%0t: got busy=%b gid=%0d ready=%b wr=%b cs=%b data=%h, required busy=%b gid=%0d ready=%b wr=%b data=%h",
                   $time, busy, grant_id, req_ready, fifo_wr_en, fifo_wr_cs, fifo_data_in,
                   c.busy, c.gid, c.ready, c.wr, c.data);
        end
        if (fifo_wr_en === 1'b1) begin
          vectors++;
          if (wr_q.size() == 0) begin
            miscompares++;
            $display("FAIL fifo_write t=%0t: unexpected write data=%h gid=%0d, required no write",
                     $time, fifo_data_in, grant_id);
          end else begin
            w = wr_q.pop_front();
            if (fifo_data_in !== w.data || grant_id !== w.gid) begin
              miscompares++;
              $display("FAIL fifo_write t=%0t: got data=%h gid=%0d, required data=%h gid=%0d",
                       $time, fifo_data_in, grant_id, w.data, w.gid);
            end
          end
        end
      end
    end
  end

  initial begin
    // Power-on reset, outputs checked by the monitor while rst is high.
    repeat (3) step();
    #2;
    rst = 1'b0;
    repeat (2) step();

    // Owner 0 goes idle after one beat while 3 waits.
    load(0, 3, 'h10, 1'b1);
    load(3, 2, 'h30, 1'b1);
    set_en(4'b1001);
    wait_size("owner_drop", 0, 2, 20);
    set_en(4'b1000);
    repeat (8) step();
    set_en(4'b1001);
    drain("owner_drop", 100);

    // Single requester 1, three-beat packet.
    load(1, 3, 'hA1, 1'b1);
    set_en(4'b0010);
    drain("single_pkt", 50);

    // All requesters continuously valid, no last: MAX_BURST rotation.
    for (int i = 0; i < N; i++) load(i, 8, (i << 4) | 8'h80, 1'b0);
    set_en(4'b1111);
    drain("rr_rotation", 200);

    // Full stall in the middle of requester 2's burst.
    load(2, 4, 'hC0, 1'b1);
    set_en(4'b0100);
    wait_size("full_stall", 2, 2, 20);
    full_hold = 5;
    drain("full_stall", 100);

    // Async reset in the middle of requester 2's burst.
    load(2, 4, 'hD0, 1'b1);
    set_en(4'b0100);
    wait_size("reset_burst", 2, 2, 20);
    do_reset(2);
    drain("reset_burst", 100);

    // Random traffic with random valid gaps and full.
    valid_pct = 80;
    full_pct  = 20;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(9) == 0) begin
        int r;
        r = $urandom_range(N-1);
        if (bq[r].size() < 6) load(r, $urandom_range(1, 5), $urandom_range(255), 1'($urandom_range(1)));
      end
      if ($urandom_range(19) == 0) set_en(N'($urandom));
      step();
    end
    valid_pct = 100;
    full_pct  = 0;
    set_en(4'b1111);
    drain("random_traffic", 2000);

    step();
    #2;
    vectors++;
    if (wr_q.size() != 0 || cyc_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: %0d writes and %0d cycles outstanding, required 0",
               wr_q.size(), cyc_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
